// File: rtl/mem_port_arbiter_if.sv
// Signal bundle between the two CPU requesters, the shared memory port and the arbiter.
// The arbiter takes the master modport; the requesters and memory model take the slave side.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              a_req;
    logic [ADDR_W-1:0] a_addr;
    logic              a_done;

    logic              b_req;
    logic              b_we;
    logic [ADDR_W-1:0] b_addr;
    logic [DATA_W-1:0] b_wdata;
    logic              b_done;

    logic [DATA_W-1:0] rdata;
    logic              err;
    logic              sel;

    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        input  a_req, a_addr, b_req, b_we, b_addr, b_wdata, mem_ack, mem_rdata,
        output a_done, b_done, rdata, err, sel, mem_req, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        output a_req, a_addr, b_req, b_we, b_addr, b_wdata, mem_ack, mem_rdata,
        input  a_done, b_done, rdata, err, sel, mem_req, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port between instruction fetch (A) and data (B),
// with a watchdog that aborts accesses the memory never acknowledges.
module mem_port_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    mem_port_arbiter_if.master bus
);
    localparam int                WDOG_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t            state;
    logic [WDOG_W-1:0] wdog;

    logic              grant_any;
    logic              grant_b;
    logic              grant_we;
    logic [ADDR_W-1:0] grant_addr;
    logic [DATA_W-1:0] grant_wdata;

    always_comb begin
        grant_any   = bus.a_req | bus.b_req;
        // sel is never changed outside a grant, so it doubles as last_grant (reset value = A).
        grant_b     = bus.b_req & (~bus.a_req | ~bus.sel);
        grant_we    = grant_b & bus.b_we;
        grant_addr  = grant_b ? bus.b_addr : bus.a_addr;
        grant_wdata = grant_b ? bus.b_wdata : '0;
    end

    // NOTE: all state and output registers use <= so every branch reads pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            wdog          <= '0;
            bus.a_done    <= 1'b0;
            bus.b_done    <= 1'b0;
            bus.rdata     <= '0;
            bus.err       <= 1'b0;
            bus.sel       <= 1'b0;
            bus.mem_req   <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_any) begin
                        bus.sel       <= grant_b;
                        bus.mem_addr  <= grant_addr;
                        bus.mem_we    <= grant_we;
                        bus.mem_wdata <= grant_wdata;
                        bus.mem_req   <= 1'b1;
                        wdog          <= '0;
                        state         <= ACCESS;
                    end
                end

                ACCESS: begin
                    wdog <= wdog + WDOG_W'(1);
                    // An ack arriving on the final watchdog cycle still completes normally.
                    if (bus.mem_ack) begin
                        bus.rdata   <= bus.mem_we ? '0 : bus.mem_rdata;
                        bus.mem_req <= 1'b0;
                        bus.a_done  <= ~bus.sel;
                        bus.b_done  <= bus.sel;
                        state       <= RESP;
                    end else if (wdog == WDOG_LAST) begin
                        bus.rdata   <= '0;
                        bus.err     <= 1'b1;
                        bus.mem_req <= 1'b0;
                        bus.a_done  <= ~bus.sel;
                        bus.b_done  <= bus.sel;
                        state       <= RESP;
                    end
                end

                RESP: begin
                    bus.a_done <= 1'b0;
                    bus.b_done <= 1'b0;
                    bus.err    <= 1'b0;
                    state      <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end
endmodule
